// File: rtl/hedios_tx_arbiter_if.sv
// Port bundle between the Hedios frame sources and the shared UART transmit byte stream.
// The arbiter connects through the slave modport. A source/UART model connects through the master modport.
interface hedios_tx_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [N_REQ-1:0]        grant;
    logic                    frame_done;
    logic                    frame_abort;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant, frame_done, frame_abort
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant, frame_done, frame_abort
    );
endinterface

// File: rtl/hedios_tx_arbiter.sv
// Round-robin frame arbiter for the Hedios UART TX stream.
// A grant lasts for one whole frame. A registered output stage drives the UART, and a stall watchdog can abort a frame.
module hedios_tx_arbiter #(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hedios_tx_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] STALL_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_abort_q, frame_abort_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic [N_REQ-1:0]    req_ready_c;
    logic                out_free;
    logic                own_valid;
    logic                own_last;
    logic [DATA_W-1:0]   own_data;
    logic                xfer;
    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    cand;

    // While busy, rr_ptr_q always names the current owner.
    assign own_valid = bus.req_valid[rr_ptr_q];
    assign own_last  = bus.req_last[rr_ptr_q];
    assign own_data  = bus.req_data[rr_ptr_q*DATA_W +: DATA_W];
    assign out_free  = !tx_valid_q || bus.tx_ready;
    assign xfer      = (state_q == BUSY) && own_valid && out_free;

    // The search starts just after the last winner, so that winner has the lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // NOTE: every signal gets a default value before any branch runs. A path that leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        stall_cnt_d   = '0;
        req_ready_c   = '0;

        // The output stage drains on its own, whatever the state.
        if (xfer) begin
            tx_valid_d = 1'b1;
            tx_data_d  = own_data;
        end else if (out_free) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = BUSY;
                    grant_d  = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    rr_ptr_d = win_idx;
                end
            end
            BUSY: begin
                req_ready_c[rr_ptr_q] = out_free;
                if (xfer) begin
                    if (own_last) begin
                        state_d      = IDLE;
                        grant_d      = '0;
                        frame_done_d = 1'b1;
                    end
                end else if (!own_valid && (TIMEOUT > 0)) begin
                    if (stall_cnt_q == STALL_LAST) begin
                        state_d       = IDLE;
                        grant_d       = '0;
                        frame_abort_d = 1'b1;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end else begin
                    // Backpressure from the UART does not count as a source stall.
                    stall_cnt_d = stall_cnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop then samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= PTR_W'(N_REQ - 1);
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.grant       = grant_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_abort = frame_abort_q;

endmodule

// File: tb/tb_hedios_tx_arbiter.sv
// Directed bench for hedios_tx_arbiter: N_REQ=2, DATA_W=8, TIMEOUT=8.
// Inputs are driven 1 ns after each rising edge. Registered outputs are checked at that same point. req_ready is checked 1 ns later.
module tb_hedios_tx_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    hedios_tx_arbiter_if #(.N_REQ(2), .DATA_W(8)) bus ();

    hedios_tx_arbiter #(.N_REQ(2), .DATA_W(8), .TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] valid, input logic [7:0] d0, input logic l0,
                         input logic [7:0] d1, input logic l1);
        bus.req_valid = valid;
        bus.req_data  = {d1, d0};
        bus.req_last  = {l1, l0};
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.tx_ready = 1'b1;
        drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b0);

        // Reset state
        repeat (2) tick();
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h0);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_pulses", 32'({bus.frame_done, bus.frame_abort}), 32'h0);

        // Test 1: both sources request at once. rr_ptr starts at 1, so src0 goes first.
        rst_n = 1'b1;
        drive(2'b11, 8'h10, 1'b0, 8'h20, 1'b0);
        #1 check("t1_idle_ready", 32'(bus.req_ready), 32'h0);
        tick();
        check("t1_grant0", 32'(bus.grant), 32'h1);
        check("t1_txv_before", 32'(bus.tx_valid), 32'h0);
        #1 check("t1_ready0", 32'(bus.req_ready), 32'h1);
        tick();
        check("t1_b0", 32'(bus.tx_data), 32'h10);
        check("t1_v0", 32'(bus.tx_valid), 32'h1);
        drive(2'b11, 8'h11, 1'b0, 8'h20, 1'b0);
        tick();
        check("t1_b1", 32'(bus.tx_data), 32'h11);
        check("t1_nodone_mid", 32'(bus.frame_done), 32'h0);
        drive(2'b11, 8'h12, 1'b1, 8'h20, 1'b0);
        tick();
        check("t1_b2", 32'(bus.tx_data), 32'h12);
        check("t1_done0", 32'(bus.frame_done), 32'h1);
        check("t1_grant_idle", 32'(bus.grant), 32'h0);
        drive(2'b10, 8'h00, 1'b0, 8'h20, 1'b0);
        tick();
        check("t1_grant1", 32'(bus.grant), 32'h2);
        check("t1_done_pulse", 32'(bus.frame_done), 32'h0);
        check("t1_txv_drained", 32'(bus.tx_valid), 32'h0);
        tick();
        check("t1_b3", 32'(bus.tx_data), 32'h20);
        drive(2'b10, 8'h00, 1'b0, 8'h21, 1'b0);
        tick();
        check("t1_b4", 32'(bus.tx_data), 32'h21);
        drive(2'b10, 8'h00, 1'b0, 8'h22, 1'b1);
        tick();
        check("t1_b5", 32'(bus.tx_data), 32'h22);
        check("t1_done1", 32'(bus.frame_done), 32'h1);

        // Test 2: src1 sends a frame. src0 requests in the middle of it and must wait.
        drive(2'b10, 8'h00, 1'b0, 8'h30, 1'b0);
        tick();
        check("t2_grant1", 32'(bus.grant), 32'h2);
        drive(2'b11, 8'h40, 1'b0, 8'h30, 1'b0);
        #1 check("t2_src0_ignored", 32'(bus.req_ready), 32'h2);
        tick();
        check("t2_b0", 32'(bus.tx_data), 32'h30);
        check("t2_grant_held", 32'(bus.grant), 32'h2);
        drive(2'b11, 8'h40, 1'b1, 8'h31, 1'b1);
        tick();
        check("t2_b1", 32'(bus.tx_data), 32'h31);
        check("t2_done", 32'(bus.frame_done), 32'h1);
        drive(2'b11, 8'h40, 1'b1, 8'h32, 1'b0);
        tick();
        check("t2_grant0", 32'(bus.grant), 32'h1);
        tick();
        check("t2_b2", 32'(bus.tx_data), 32'h40);
        check("t2_done0", 32'(bus.frame_done), 32'h1);
        tick();
        check("t2_next_to_src1", 32'(bus.grant), 32'h2);

        // Test 3: UART backpressure holds 0xA5 stable for 5 cycles.
        drive(2'b10, 8'h00, 1'b0, 8'hA5, 1'b0);
        tick();
        check("t3_a5", 32'(bus.tx_data), 32'hA5);
        check("t3_a5_valid", 32'(bus.tx_valid), 32'h1);
        bus.tx_ready = 1'b0;
        drive(2'b10, 8'h00, 1'b0, 8'hA6, 1'b0);
        #1 check("t3_ready_low", 32'(bus.req_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_data", 32'(bus.tx_data), 32'hA5);
            check("t3_hold_valid", 32'(bus.tx_valid), 32'h1);
            check("t3_hold_grant", 32'(bus.grant), 32'h2);
            #1 check("t3_hold_ready", 32'(bus.req_ready), 32'h0);
        end
        bus.tx_ready = 1'b1;
        #1 check("t3_ready_back", 32'(bus.req_ready), 32'h2);
        tick();
        check("t3_a6", 32'(bus.tx_data), 32'hA6);
        drive(2'b10, 8'h00, 1'b0, 8'hA7, 1'b1);
        tick();
        check("t3_a7", 32'(bus.tx_data), 32'hA7);
        check("t3_done", 32'(bus.frame_done), 32'h1);

        // Test 4: src0 stalls after one byte. The watchdog aborts the frame 8 cycles after the transfer.
        drive(2'b11, 8'h50, 1'b0, 8'h60, 1'b0);
        tick();
        check("t4_grant0", 32'(bus.grant), 32'h1);
        tick();
        check("t4_b0", 32'(bus.tx_data), 32'h50);
        drive(2'b10, 8'h00, 1'b0, 8'h60, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("t4_no_abort_yet", 32'(bus.frame_abort), 32'h0);
            check("t4_grant_kept", 32'(bus.grant), 32'h1);
        end
        tick();
        check("t4_abort", 32'(bus.frame_abort), 32'h1);
        check("t4_abort_nodone", 32'(bus.frame_done), 32'h0);
        check("t4_abort_grant", 32'(bus.grant), 32'h0);
        tick();
        check("t4_abort_pulse", 32'(bus.frame_abort), 32'h0);
        check("t4_grant1", 32'(bus.grant), 32'h2);
        drive(2'b10, 8'h00, 1'b0, 8'h60, 1'b1);
        tick();
        check("t4_b1", 32'(bus.tx_data), 32'h60);
        check("t4_done1", 32'(bus.frame_done), 32'h1);

        // Test 5: src0 sends a single-byte frame
        drive(2'b01, 8'h3C, 1'b1, 8'h00, 1'b0);
        tick();
        check("t5_grant0", 32'(bus.grant), 32'h1);
        #1 check("t5_ready0", 32'(bus.req_ready), 32'h1);
        tick();
        check("t5_data", 32'(bus.tx_data), 32'h3C);
        check("t5_valid", 32'(bus.tx_valid), 32'h1);
        check("t5_done", 32'(bus.frame_done), 32'h1);
        check("t5_grant_idle", 32'(bus.grant), 32'h0);
        drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check("t5_done_pulse", 32'(bus.frame_done), 32'h0);
        check("t5_txv_drained", 32'(bus.tx_valid), 32'h0);

        // Test 6: asynchronous reset in the middle of a frame while tx_valid is high
        bus.tx_ready = 1'b0;
        drive(2'b01, 8'h70, 1'b0, 8'h00, 1'b0);
        tick();
        check("t6_grant0", 32'(bus.grant), 32'h1);
        tick();
        check("t6_pre_valid", 32'(bus.tx_valid), 32'h1);
        check("t6_pre_data", 32'(bus.tx_data), 32'h70);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus.tx_valid), 32'h0);
        check("t6_async_grant", 32'(bus.grant), 32'h0);
        check("t6_async_ready", 32'(bus.req_ready), 32'h0);
        check("t6_async_data", 32'(bus.tx_data), 32'h0);
        tick();
        rst_n = 1'b1;
        bus.tx_ready = 1'b1;
        drive(2'b11, 8'h80, 1'b0, 8'h90, 1'b0);
        tick();
        check("t6_src0_priority", 32'(bus.grant), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
